// File: rtl/occf_sink_pkg.sv
// occf_sink_pkg: shared FSM encoding and width helpers for the OCC fabric sink
package occf_sink_pkg;
  typedef enum logic [1:0] {S_IDLE, S_IN_FRAME, S_TRUNC} t_occf_state;
  function automatic int c_OCCF_SEL_WIDTH(input int dw);
    return dw / 8;
  endfunction
  function automatic int f_count_width(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int f_ptr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/occf_sync_fifo.sv
// occf_sync_fifo: synchronous show-ahead FIFO with occupancy output, RAM or flop-bank storage
module occf_sync_fifo
  import occf_sink_pkg::*;
#(
  parameter int g_WIDTH = 8,
  parameter int g_DEPTH = 8,
  parameter int g_WITH_FIFO_INFERRED = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  logic                                pop_i,
  input  logic [g_WIDTH-1:0]                  wdata_i,
  output logic [g_WIDTH-1:0]                  rdata_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [f_count_width(g_DEPTH)-1:0]   level_o
);
  localparam int PW = f_ptr_width(g_DEPTH);
  localparam int VW = f_count_width(g_DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty_o = level_o == '0;
  assign full_o = level_o == VW'(g_DEPTH);
  assign do_pop = pop_i & ~empty_o;
  // a push into a full FIFO is dropped unless a pop frees the slot this cycle
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      level_o <= level_o + VW'(do_push) - VW'(do_pop);
    end
  generate
    if (g_WITH_FIFO_INFERRED != 0) begin : g_ram
      logic [g_WIDTH-1:0] mem [g_DEPTH];
      always_ff @(posedge clk_i)
        if (do_push) mem[wr_ptr] <= wdata_i;
      assign rdata_o = mem[rd_ptr];
    end else begin : g_regs
      logic [g_WIDTH-1:0] regs [g_DEPTH];
      always_ff @(posedge clk_i)
        if (rst_i) regs <= '{default: '0};
        else for (int k = 0; k < g_DEPTH; k++) if (do_push && wr_ptr == PW'(k)) regs[k] <= wdata_i;
      assign rdata_o = regs[rd_ptr];
    end
  endgenerate
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i));
endmodule

// File: rtl/wb_occf_sink_gen.sv
// wb_occf_sink_gen: pipelined Wishbone stream sink; frames words by CYC, buffers them,
// and hands them to user logic under dreq_i with truncation, frame length and level reporting
module wb_occf_sink_gen
  import occf_sink_pkg::*;
#(
  parameter int g_DATA_WIDTH = 128,
  parameter int g_ADDR_WIDTH = 4,
  parameter int g_FIFO_DEPTH = 8,
  parameter int g_STALL_MARGIN = 2,
  parameter int g_MAX_FRAME_WORDS = 1024,
  parameter int g_WITH_FIFO_INFERRED = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [g_DATA_WIDTH-1:0]                       snk_dat_i,
  input  logic [g_ADDR_WIDTH-1:0]                       snk_adr_i,
  input  logic [g_DATA_WIDTH/8-1:0]                     snk_sel_i,
  input  logic                                          snk_cyc_i,
  input  logic                                          snk_stb_i,
  input  logic                                          snk_we_i,
  output logic                                          snk_stall_o,
  output logic                                          snk_ack_o,
  output logic                                          snk_err_o,
  output logic                                          snk_rty_o,
  output logic [g_ADDR_WIDTH-1:0]                       addr_o,
  output logic [g_DATA_WIDTH-1:0]                       data_o,
  output logic [g_DATA_WIDTH/8-1:0]                     bytesel_o,
  output logic                                          dvalid_o,
  output logic                                          sof_o,
  output logic                                          eof_o,
  output logic                                          frame_err_o,
  output logic [f_count_width(g_MAX_FRAME_WORDS)-1:0]   frame_len_o,
  output logic [f_count_width(g_FIFO_DEPTH)-1:0]        fifo_level_o,
  input  logic                                          dreq_i
);
  localparam int SW = c_OCCF_SEL_WIDTH(g_DATA_WIDTH);
  localparam int LW = f_count_width(g_MAX_FRAME_WORDS);
  localparam int VW = f_count_width(g_FIFO_DEPTH);
  localparam logic [VW-1:0] STALL_LVL = VW'(g_FIFO_DEPTH - g_STALL_MARGIN);
  localparam logic [LW-1:0] LAST_CNT = LW'(g_MAX_FRAME_WORDS - 1);
  typedef struct packed {
    logic                    err;
    logic [LW-1:0]           len;
    logic                    eof;
    logic                    sof;
    logic [SW-1:0]           sel;
    logic [g_ADDR_WIDTH-1:0] adr;
    logic [g_DATA_WIDTH-1:0] dat;
  } t_occf_word;
  localparam int FW = $bits(t_occf_word);
  t_occf_state state_q, state_n;
  t_occf_word hold_q, fifo_wr, fifo_rd;
  logic hold_v_q, stall_q;
  logic [LW-1:0] cnt_q;
  logic accept, err_ev, push, push_last, pop, fifo_empty, fifo_full;
  logic [VW-1:0] level;
  assign snk_stall_o = stall_q | rst_i;
  assign snk_rty_o = 1'b0;
  assign fifo_level_o = level;
  always_ff @(posedge clk_i) state_q <= rst_i ? S_IDLE : state_n;
  always_comb state_n = !snk_cyc_i ? S_IDLE
                      : (accept && cnt_q == LAST_CNT) ? S_TRUNC
                      : (accept && state_q == S_IDLE) ? S_IN_FRAME : state_q;
  // the held word is flushed as last either once truncation is reached or when CYC drops
  always_comb begin
    accept = snk_cyc_i & snk_stb_i & snk_we_i & ~snk_stall_o & (state_q != S_TRUNC);
    err_ev = snk_cyc_i & snk_stb_i & ~snk_stall_o & (~snk_we_i | state_q == S_TRUNC);
    push_last = hold_v_q & (state_q == S_TRUNC | ~snk_cyc_i);
    push = (accept & hold_v_q) | push_last;
    fifo_wr = hold_q;
    fifo_wr.eof = push_last;
    fifo_wr.err = push_last & (state_q == S_TRUNC);
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      hold_v_q <= 1'b0;
      hold_q <= '0;
      cnt_q <= '0;
      stall_q <= 1'b1;
      snk_ack_o <= 1'b0;
      snk_err_o <= 1'b0;
    end else begin
      stall_q <= level >= STALL_LVL || fifo_full;
      snk_ack_o <= accept;
      snk_err_o <= err_ev;
      cnt_q <= !snk_cyc_i ? '0 : accept ? cnt_q + LW'(1) : cnt_q;
      hold_v_q <= accept | (hold_v_q & ~push);
      if (accept) hold_q <= '{err: 1'b0, len: cnt_q + LW'(1), eof: 1'b0, sof: state_q == S_IDLE,
                             sel: snk_sel_i, adr: snk_adr_i, dat: snk_dat_i};
    end
  occf_sync_fifo #(
    .g_WIDTH(FW),
    .g_DEPTH(g_FIFO_DEPTH),
    .g_WITH_FIFO_INFERRED(g_WITH_FIFO_INFERRED)
  ) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(fifo_wr),
    .rdata_o(fifo_rd),
    .empty_o(fifo_empty),
    .full_o(fifo_full),
    .level_o(level)
  );
  assign pop = dreq_i & ~fifo_empty;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      dvalid_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      frame_err_o <= 1'b0;
      frame_len_o <= '0;
      data_o <= '0;
      addr_o <= '0;
      bytesel_o <= '0;
    end else begin
      dvalid_o <= pop;
      sof_o <= pop & fifo_rd.sof;
      eof_o <= pop & fifo_rd.eof;
      frame_err_o <= pop & fifo_rd.err;
      frame_len_o <= (pop & fifo_rd.eof) ? fifo_rd.len : '0;
      if (pop) begin
        data_o <= fifo_rd.dat;
        addr_o <= fifo_rd.adr;
        bytesel_o <= fifo_rd.sel;
      end
    end
endmodule

// File: tb/tb_wb_occf_sink_gen.sv
// tb_wb_occf_sink_gen: scoreboard bench for the OCC sink; u_dut keeps 1024-word frames,
// u_trn truncates at 16 words and uses the flop-bank FIFO
module tb_wb_occf_sink_gen;
  typedef struct packed {
    logic [127:0] dat;
    logic [3:0]   adr;
    logic [15:0]  sel;
    logic         sof;
    logic         eof;
    logic         err;
    logic [10:0]  len;
  } exp_t;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 1, dreq = 0, use_trn = 0;
  logic [127:0] dat = '0;
  logic [3:0] adr = '0;
  logic [15:0] sel = '0;
  logic a_stall, a_ack, a_err, a_rty, a_dv, a_sof, a_eof, a_ferr;
  logic b_stall, b_ack, b_err, b_rty, b_dv, b_sof, b_eof, b_ferr;
  logic [3:0] a_adr, b_adr, a_lvl, b_lvl;
  logic [127:0] a_dat, b_dat;
  logic [15:0] a_sel, b_sel;
  logic [10:0] a_len;
  logic [4:0] b_len;
  logic stall_m;
  exp_t qa[$], qb[$];
  int total = 0, bad = 0, exp_ack = 0, exp_err = 0;
  int a_acks = 0, a_errs = 0, b_acks = 0, b_errs = 0;
  logic pa_rst = 1, pb_rst = 1, p_dreq = 0;
  logic [3:0] pa_lvl = '0, pb_lvl = '0;

  always #5 clk = ~clk;
  assign stall_m = use_trn ? b_stall : a_stall;

  wb_occf_sink_gen #(.g_DATA_WIDTH(128), .g_ADDR_WIDTH(4), .g_FIFO_DEPTH(8), .g_STALL_MARGIN(2),
                     .g_MAX_FRAME_WORDS(1024), .g_WITH_FIFO_INFERRED(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(sel),
    .snk_cyc_i(cyc & ~use_trn), .snk_stb_i(stb & ~use_trn), .snk_we_i(we),
    .snk_stall_o(a_stall), .snk_ack_o(a_ack), .snk_err_o(a_err), .snk_rty_o(a_rty),
    .addr_o(a_adr), .data_o(a_dat), .bytesel_o(a_sel), .dvalid_o(a_dv), .sof_o(a_sof),
    .eof_o(a_eof), .frame_err_o(a_ferr), .frame_len_o(a_len), .fifo_level_o(a_lvl), .dreq_i(dreq));

  wb_occf_sink_gen #(.g_DATA_WIDTH(128), .g_ADDR_WIDTH(4), .g_FIFO_DEPTH(8), .g_STALL_MARGIN(2),
                     .g_MAX_FRAME_WORDS(16), .g_WITH_FIFO_INFERRED(0)) u_trn (
    .clk_i(clk), .rst_i(rst), .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(sel),
    .snk_cyc_i(cyc & use_trn), .snk_stb_i(stb & use_trn), .snk_we_i(we),
    .snk_stall_o(b_stall), .snk_ack_o(b_ack), .snk_err_o(b_err), .snk_rty_o(b_rty),
    .addr_o(b_adr), .data_o(b_dat), .bytesel_o(b_sel), .dvalid_o(b_dv), .sof_o(b_sof),
    .eof_o(b_eof), .frame_err_o(b_ferr), .frame_len_o(b_len), .fifo_level_o(b_lvl), .dreq_i(dreq));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // output scoreboards plus registered-stall and dreq-gating rules, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (a_dv) begin
      chk("a_dreq_gate", p_dreq, 1);
      if (qa.size() == 0) chk("a_unexpected", a_dv, 0);
      else begin
        e = qa.pop_front();
        chk("a_data", a_dat, e.dat);
        chk("a_tag", {a_adr, a_sel}, {e.adr, e.sel});
        chk("a_flags", {a_sof, a_eof, a_ferr}, {e.sof, e.eof, e.err});
        if (e.eof) chk("a_len", a_len, e.len);
      end
    end
    if (b_dv) begin
      chk("b_dreq_gate", p_dreq, 1);
      if (qb.size() == 0) chk("b_unexpected", b_dv, 0);
      else begin
        e = qb.pop_front();
        chk("b_data", b_dat, e.dat);
        chk("b_tag", {b_adr, b_sel}, {e.adr, e.sel});
        chk("b_flags", {b_sof, b_eof, b_ferr}, {e.sof, e.eof, e.err});
        if (e.eof) chk("b_len", b_len, e.len);
      end
    end
    chk("a_stall_rule", a_stall, rst | pa_rst | (pa_lvl >= 4'd6));
    chk("b_stall_rule", b_stall, rst | pb_rst | (pb_lvl >= 4'd6));
    if (a_ack) a_acks++;
    if (a_err) a_errs++;
    if (b_ack) b_acks++;
    if (b_err) b_errs++;
    pa_rst = rst;
    pb_rst = rst;
    pa_lvl = a_lvl;
    pb_lvl = b_lvl;
    p_dreq = dreq;
  end

  task automatic put(input logic [127:0] d, input logic [3:0] a, input logic [15:0] s, input logic w);
    bit ok = 0;
    dat = d;
    adr = a;
    sel = s;
    we = w;
    stb = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall_m) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("stall_timeout", ok, 1);
    @(posedge clk);
    #1;
    stb = 0;
    we = 1;
  endtask

  task automatic frame(input int n, input int bad_at, input bit trn);
    int mx;
    exp_t e;
    logic [127:0] d;
    logic [3:0] a;
    logic [15:0] s;
    mx = trn ? 16 : 1024;
    cyc = 1;
    for (int i = 0; i < n; i++) begin
      if (i == bad_at) begin
        put(128'hDEAD, 4'h0, 16'hFFFF, 1'b0);
        exp_err++;
      end
      d = (n == 1) ? 128'hA5 : {$urandom, $urandom, $urandom, $urandom};
      a = 4'($urandom);
      s = 16'($urandom);
      put(d, a, s, 1'b1);
      if (i < mx) begin
        e = '{dat: d, adr: a, sel: s, sof: i == 0, eof: (i == n - 1) || (i == mx - 1),
              err: i == mx - 1, len: 11'(i + 1)};
        if (trn) qb.push_back(e);
        else qa.push_back(e);
        exp_ack++;
      end else exp_err++;
    end
    cyc = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int i = 0; i < 3000 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
    chk("drain", qa.size() + qb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_stall", a_stall, 1);
    chk("rst_ack", a_ack, 0);
    chk("rst_dvalid", a_dv, 0);
    chk("rst_level", a_lvl, 0);
    chk("rst_data", a_dat, 0);
    @(posedge clk);
    #1;
    rst = 0;
    dreq = 1;
    repeat (2) @(posedge clk);
    #1;
    frame(1, -1, 0);
    drain();
    for (int f = 0; f < 4; f++) begin
      frame($urandom_range(16, 1023), -1, 0);
      drain();
    end
    frame(12, 5, 0);
    drain();
    chk("we0_err_count", a_errs + b_errs, exp_err);
    dreq = 0;
    fork
      frame(20, -1, 0);
      begin
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (a_stall) begin
            seen = 1;
            break;
          end
        end
        chk("stall_seen", seen, 1);
        chk("stall_level", a_lvl >= 4'd6, 1);
        repeat (10) @(negedge clk);
        chk("stall_hold", a_stall, 1);
        @(posedge clk);
        #1;
        dreq = 1;
      end
    join
    drain();
    use_trn = 1;
    frame(20, -1, 1);
    drain();
    use_trn = 0;
    chk("trunc_err_count", b_errs, 4);
    chk("trunc_ack_count", b_acks, 16);
    dreq = 0;
    cyc = 1;
    for (int i = 0; i < 5; i++) begin
      put({$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 16'($urandom), 1'b1);
      exp_ack++;
    end
    dat = 128'hBAD;
    stb = 1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    stb = 0;
    cyc = 0;
    @(negedge clk);
    chk("midrst_level", a_lvl, 0);
    chk("midrst_stall", a_stall, 1);
    dreq = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_acks", a_acks + b_acks, exp_ack);
    frame(3, -1, 0);
    drain();
    chk("total_acks", a_acks + b_acks, exp_ack);
    chk("total_errs", a_errs + b_errs, exp_err);
    chk("rty_tied", a_rty | b_rty, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
